spr_arb: RTL and testbench

SPR_ARB -- requirements
Module: spr_arb

---
 rtl/spr_arb.sv | 68 ++++++
 tb/tb_spr_arb.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/spr_arb.sv
// spr_arb: round-robin arbiter sharing one registered-read single-port RAM between two requesters.
module spr_arb #(
  parameter int DATA_W = 8,
  parameter int ADD_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADD_W-1:0]  add0,
  input  logic [ADD_W-1:0]  add1,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_we,
  output logic [ADD_W-1:0]  ram_add,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, RDATA} state_t;
  state_t state, state_n;
  logic owner, last, win, cmd_we, act, rd;
  logic [DATA_W-1:0] rdata_q;
  assign win = (req0 && req1) ? ~last : req1;
  always_comb begin
    state_n = IDLE;
    state_n = (state == IDLE) ? ((req0 || req1) ? ACCESS : IDLE) :
              (state == ACCESS) ? (cmd_we ? IDLE : RDATA) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      last    <= 1'b1;
      owner   <= 1'b0;
      cmd_we  <= 1'b0;
      ram_add <= '0;
      ram_din <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && (req0 || req1)) begin
        owner   <= win;
        last    <= win;
        cmd_we  <= win ? we1 : we0;
        ram_add <= win ? add1 : add0;
        ram_din <= win ? din1 : din0;
      end
      if (state == RDATA) rdata_q <= ram_dout;
    end
  end
  // a reset arriving mid-operation suppresses the pulses of the cycle it is seen in
  assign act     = (state == ACCESS) && !rst;
  assign rd      = (state == RDATA) && !rst;
  assign gnt0    = act && !owner;
  assign gnt1    = act && owner;
  assign ram_we  = act && cmd_we;
  assign rvalid0 = rd && !owner;
  assign rvalid1 = rd && owner;
  assign rdata   = rd ? ram_dout : rdata_q;
  assign busy    = state != IDLE;
endmodule

// File: tb/tb_spr_arb.sv
// tb_spr_arb: randomized and directed checks of spr_arb against a transaction-level model.
module tb_spr_arb;
  localparam int DW = 8;
  localparam int AW = 4;
  logic clk = 0, rst = 1, req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [AW-1:0] add0 = 0, add1 = 0, ram_add;
  logic [DW-1:0] din0 = 0, din1 = 0, ram_din, rdata, ram_dout = 0;
  logic gnt0, gnt1, rvalid0, rvalid1, ram_we, busy;
  logic [DW-1:0] ram [16];
  int checks = 0, errors = 0;
  bit rand_en = 0;
  always #5 clk = ~clk;
  spr_arb #(.DATA_W(DW), .ADD_W(AW)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .add0(add0), .add1(add1), .din0(din0), .din1(din1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .ram_we(ram_we), .ram_add(ram_add), .ram_din(ram_din), .ram_dout(ram_dout), .busy(busy)
  );
  always @(posedge clk) begin
    if (ram_we) ram[ram_add] <= ram_din;
    ram_dout <= ram[ram_add];
  end
  // transaction model: one outstanding command, accepted at cycle acc
  int cyc = 0, acc = -10;
  bit inited = 0, live = 0, m_owner = 0, m_last = 1, m_we = 0;
  logic [AW-1:0] m_add = 0;
  logic [DW-1:0] m_din = 0, m_rdata = 0;
  logic [DW-1:0] mem [16];
  initial for (int i = 0; i < 16; i++) begin ram[i] = 0; mem[i] = 0; end
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      inited = 1; live = 0; m_last = 1; m_add = 0; m_din = 0; m_rdata = 0;
    end else if (!live) begin
      if (req0 || req1) begin
        m_owner = (req0 && req1) ? !m_last : req1;
        m_last = m_owner;
        m_we = m_owner ? we1 : we0;
        m_add = m_owner ? add1 : add0;
        m_din = m_owner ? din1 : din0;
        acc = cyc;
        live = 1;
      end
    end else if (m_we && cyc - acc == 1) begin
      mem[m_add] = m_din;
      live = 0;
    end else if (!m_we && cyc - acc == 2) begin
      m_rdata = mem[m_add];
      live = 0;
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  int gq[$], rq[$], rdq[$];
  int gcount = 0, rcount = 0;
  bit g_own, g_we, r_own;
  logic [AW-1:0] g_add;
  logic [DW-1:0] g_din, r_data;
  always @(negedge clk) begin : compare
    bit ea, er;
    if (inited) begin
      ea = live && (cyc - acc == 0) && !rst;
      er = live && !m_we && (cyc - acc == 1) && !rst;
      chk("gnt0", gnt0, ea && !m_owner);
      chk("gnt1", gnt1, ea && m_owner);
      chk("ram_we", ram_we, ea && m_we);
      chk("rvalid0", rvalid0, er && !m_owner);
      chk("rvalid1", rvalid1, er && m_owner);
      chk("rdata", rdata, er ? mem[m_add] : m_rdata);
      chk("ram_add", ram_add, m_add);
      chk("ram_din", ram_din, m_din);
      chk("busy", busy, live);
      chk("one_pulse", (32'(gnt0) + gnt1 + rvalid0 + rvalid1) <= 1, 1);
      if (gnt0 || gnt1) begin
        gq.push_back(int'(gnt1)); g_own = gnt1; g_we = ram_we; g_add = ram_add; g_din = ram_din; gcount++;
      end
      if (rvalid0 || rvalid1) begin
        rq.push_back(int'(rvalid1)); rdq.push_back(int'(rdata)); r_own = rvalid1; r_data = rdata; rcount++;
      end
    end
  end
  // requesters: drop req after gnt and scramble the command; optionally raise new random requests
  initial forever begin
    bit g0, g1;
    @(negedge clk);
    g0 = gnt0; g1 = gnt1;
    #1;
    if (g0) begin req0 = 0; we0 = 1'($urandom); add0 = AW'($urandom); din0 = rand_en ? DW'($urandom) : 8'hFF; end
    if (g1) begin req1 = 0; we1 = 1'($urandom); add1 = AW'($urandom); din1 = rand_en ? DW'($urandom) : 8'hFF; end
    if (rand_en) begin
      if (!req0 && !g0 && $urandom_range(0, 2) == 0) begin
        req0 = 1; we0 = 1'($urandom); add0 = AW'($urandom); din0 = DW'($urandom);
      end
      if (!req1 && !g1 && $urandom_range(0, 2) == 0) begin
        req1 = 1; we1 = 1'($urandom); add1 = AW'($urandom); din1 = DW'($urandom);
      end
      rst = ($urandom_range(0, 150) == 0);
    end
  end
  task automatic issue(input bit i, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (i) begin req1 = 1; we1 = w; add1 = a; din1 = d; end
    else begin req0 = 1; we0 = w; add0 = a; din0 = d; end
  endtask
  task automatic wait_idle(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while ((req0 || req1 || busy) && n < 60);
    chk(nm, 32'(req0 || req1 || busy), 0);
  endtask
  initial begin
    int n, g_before, r_before;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_ram_add", ram_add, 0);
    chk("rst_ram_din", ram_din, 0);
    #2 rst = 0;
    @(negedge clk); #2 issue(0, 1, 5, 8'h20);
    wait_idle("wr_done");
    chk("wr_owner", g_own, 0); chk("wr_we", g_we, 1); chk("wr_add", g_add, 5); chk("wr_din", g_din, 8'h20);
    #2 issue(0, 0, 5, 8'h00);
    wait_idle("rd_done");
    chk("rd_owner", r_own, 0); chk("rd_data", r_data, 8'h20);
    #2 rst = 1;
    @(negedge clk); #2 rst = 0;
    gq.delete(); rq.delete(); rdq.delete();
    issue(0, 1, 0, 8'h10); issue(1, 1, 7, 8'h40);
    wait_idle("pair1_done");
    chk("pair1_count", gq.size(), 2);
    if (gq.size() == 2) begin chk("pair1_first", gq[0], 0); chk("pair1_second", gq[1], 1); end
    gq.delete();
    #2 issue(0, 0, 0, 8'h00); issue(1, 0, 7, 8'h00);
    wait_idle("pair2_done");
    chk("pair2_count", gq.size(), 2);
    chk("pair2_rv_count", rq.size(), 2);
    if (gq.size() == 2) chk("pair2_first", gq[0], 0);
    if (rq.size() == 2) begin
      chk("pair2_rv_first", rq[0], 0); chk("pair2_rd_first", rdq[0], 8'h10);
      chk("pair2_rv_second", rq[1], 1); chk("pair2_rd_second", rdq[1], 8'h40);
    end
    #2 issue(1, 0, 7, 8'h00);
    n = 0;
    do begin @(negedge clk); n++; end while (!gnt1 && n < 10);
    chk("midrd_gnt1", gnt1, 1);
    r_before = rcount;
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    chk("midrd_rvalid1", rvalid1, 0);
    @(negedge clk);
    chk("midrd_busy", busy, 0); chk("midrd_rdata", rdata, 0); chk("midrd_ram_add", ram_add, 0);
    chk("midrd_no_rv", rcount - r_before, 0);
    #2 rst = 0; issue(0, 0, 0, 8'h00);
    wait_idle("after_rst_done");
    chk("after_rst_owner", r_own, 0); chk("after_rst_data", r_data, 8'h10);
    g_before = gcount; r_before = rcount;
    repeat (20) begin @(negedge clk); chk("idle_busy", busy, 0); chk("idle_we", ram_we, 0); end
    chk("idle_gnts", gcount - g_before, 0); chk("idle_rvs", rcount - r_before, 0);
    rand_en = 1;
    repeat (3000) @(negedge clk);
    rand_en = 0;
    #2 rst = 0;
    wait_idle("drain");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
